// File: rtl/leitor_display_7seg_if.sv
// Display readback bus: the scanned anode/segment lines coming in, and the
// reconstructed digits, validity mask, frame pulse and sticky error flags
// going out. The stopwatch scanner side is the master, the readback block
// is the slave.
interface leitor_display_7seg_if #(
  parameter int N_DIGITS = 4
);

  logic [N_DIGITS-1:0]   an_in;
  logic [6:0]            seg_in;
  logic                  clr_err;
  logic [4*N_DIGITS-1:0] digits_out;
  logic [N_DIGITS-1:0]   digit_valid;
  logic                  frame_done;
  logic                  err_invalid;
  logic                  err_collision;

  modport master (
    output an_in,
    output seg_in,
    output clr_err,
    input  digits_out,
    input  digit_valid,
    input  frame_done,
    input  err_invalid,
    input  err_collision
  );

  modport slave (
    input  an_in,
    input  seg_in,
    input  clr_err,
    output digits_out,
    output digit_valid,
    output frame_done,
    output err_invalid,
    output err_collision
  );

endinterface

// File: rtl/leitor_display_7seg.sv
// Readback of a multiplexed active-low 7-segment display. Each selected digit
// must hold the same anode/segment pattern for STABLE_CYCLES registered
// samples before it is reverse-decoded to BCD and stored. A frame pulse is
// produced once every digit has been captured, and sticky flags report
// unrecognised patterns and multiple simultaneously active anodes.
module leitor_display_7seg #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  leitor_display_7seg_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    CAPTURED
  } state_t;

  state_t                state_q, state_d;
  logic [N_DIGITS-1:0]   anR_q;
  logic [6:0]            segR_q;
  logic [N_DIGITS-1:0]   anL_q, anL_d;
  logic [6:0]            segL_q, segL_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic                  frameDone_q, frameDone_d;
  logic                  errInvalid_q, errInvalid_d;
  logic                  errCollision_q, errCollision_d;

  logic [3:0]            zeroCount;
  logic                  oneHot;
  logic                  collision;
  logic                  match;
  logic                  doCapture;
  logic [3:0]            decValue;
  logic                  decIsDigit;
  logic                  decIsInvalid;

  // Register the raw pins so every decision works on a clean sampled copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anR_q  <= '1;
      segR_q <= 7'h7F;
    end else begin
      anR_q  <= bus.an_in;
      segR_q <= bus.seg_in;
    end
  end

  // Count selected anodes; exactly one is a digit, two or more is a collision.
  always_comb begin
    zeroCount = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      zeroCount = zeroCount + {3'b000, ~anR_q[i]};
    end
    oneHot    = (zeroCount == 4'd1);
    collision = (zeroCount > 4'd1);
    match     = (anR_q == anL_q) && (segR_q == segL_q);
  end

  // Reverse-decode the latched segment pattern (g..a, active-low) to BCD.
  always_comb begin
    decValue     = 4'hE;
    decIsDigit   = 1'b0;
    decIsInvalid = 1'b0;
    case (segL_q)
      7'b1000000: begin decValue = 4'd0; decIsDigit = 1'b1; end
      7'b1111001: begin decValue = 4'd1; decIsDigit = 1'b1; end
      7'b0100100: begin decValue = 4'd2; decIsDigit = 1'b1; end
      7'b0110000: begin decValue = 4'd3; decIsDigit = 1'b1; end
      7'b0011001: begin decValue = 4'd4; decIsDigit = 1'b1; end
      7'b0010010: begin decValue = 4'd5; decIsDigit = 1'b1; end
      7'b0000010: begin decValue = 4'd6; decIsDigit = 1'b1; end
      7'b1111000: begin decValue = 4'd7; decIsDigit = 1'b1; end
      7'b0000000: begin decValue = 4'd8; decIsDigit = 1'b1; end
      7'b0010000: begin decValue = 4'd9; decIsDigit = 1'b1; end
      7'b1111111: begin decValue = 4'hF; end
      default:    begin decValue = 4'hE; decIsInvalid = 1'b1; end
    endcase
  end

  // Settling FSM, capture into the digit store, frame tracking and sticky errors.
  always_comb begin
    state_d   = state_q;
    anL_d     = anL_q;
    segL_d    = segL_q;
    cnt_d     = cnt_q;
    doCapture = 1'b0;

    case (state_q)
      IDLE: begin
        if (oneHot) begin
          anL_d   = anR_q;
          segL_d  = segR_q;
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (match) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX - 1'b1) begin
            doCapture = 1'b1;
            state_d   = CAPTURED;
          end
        end else if (oneHot) begin
          anL_d  = anR_q;
          segL_d = segR_q;
          cnt_d  = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURED: begin
        if (!match) begin
          if (oneHot) begin
            anL_d   = anR_q;
            segL_d  = segR_q;
            cnt_d   = CNT_ONE;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (collision) begin
      state_d   = IDLE;
      doCapture = 1'b0;
    end

    digits_d    = digits_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    frameDone_d = 1'b0;
    if (seen_q == {N_DIGITS{1'b1}}) begin
      frameDone_d = 1'b1;
      seen_d      = '0;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (doCapture && !anL_q[i]) begin
        digits_d[4*i +: 4] = decValue;
        valid_d[i]         = decIsDigit;
        seen_d[i]          = 1'b1;
      end
    end

    errInvalid_d   = bus.clr_err ? 1'b0 : errInvalid_q;
    errCollision_d = bus.clr_err ? 1'b0 : errCollision_q;
    if (doCapture && decIsInvalid) begin
      errInvalid_d = 1'b1;
    end
    if (collision) begin
      errCollision_d = 1'b1;
    end
  end

  // State and result registers; reset discards any partial count or frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      anL_q          <= '1;
      segL_q         <= 7'h7F;
      cnt_q          <= '0;
      seen_q         <= '0;
      digits_q       <= '1;
      valid_q        <= '0;
      frameDone_q    <= 1'b0;
      errInvalid_q   <= 1'b0;
      errCollision_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      anL_q          <= anL_d;
      segL_q         <= segL_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      digits_q       <= digits_d;
      valid_q        <= valid_d;
      frameDone_q    <= frameDone_d;
      errInvalid_q   <= errInvalid_d;
      errCollision_q <= errCollision_d;
    end
  end

  assign bus.digits_out    = digits_q;
  assign bus.digit_valid   = valid_q;
  assign bus.frame_done    = frameDone_q;
  assign bus.err_invalid   = errInvalid_q;
  assign bus.err_collision = errCollision_q;

endmodule

// File: doc/leitor_display_7seg.md
# leitor_display_7seg

Capture block that reads back a multiplexed, active-low 7-segment display bus and reconstructs the BCD digits being shown. It sits beside the display scanner in the stopwatch top level as a self-check and readback path. It watches the anode and segment lines, waits for each digit to settle, and reverse-decodes the segment pattern to BCD. It also stores per-digit results, flags invalid or colliding patterns, and pulses once per completed display frame.

## Interface
Parameters:
- N_DIGITS, 4: number of multiplexed digits, legal 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before capture, legal 2..255.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- an_in  in  N_DIGITS  anode enables, active-low; bit i low selects digit i.
- seg_in  in  7  segment lines (g,f,e,d,c,b,a), active-low.
- clr_err  in  1  synchronous clear of sticky error flags.
- digits_out  out  4*N_DIGITS  captured BCD, digit i at [4i+3:4i].
- digit_valid  out  N_DIGITS  bit i set when digit i holds a decoded 0-9.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse.
- err_invalid  out  1  sticky: an unrecognised segment pattern was captured.
- err_collision  out  1  sticky: more than one anode was active in a sample.

The block has one clock. Reset is synchronous and active-low.

## Operation
- Input stage: an_in and seg_in are registered into an_r and seg_r every cycle. All decisions use the registered copies.
- One-hot test: an_r has exactly one zero bit. An all-ones an_r means no digit is selected and is not an error.
- FSM states:
  - IDLE: if an_r is one-hot, latch an_r/seg_r into an_l/seg_l, set cnt=1, and go to COUNT.
  - COUNT: if an_r==an_l and seg_r==seg_l, increment cnt. When cnt reaches STABLE_CYCLES, capture and go to CAPTURED.
  - COUNT on a mismatch: if the new an_r is one-hot, relatch it with cnt=1 and stay in COUNT. Otherwise go to IDLE.
  - CAPTURED: hold while an_r==an_l and seg_r==seg_l. On any change, apply the IDLE evaluation in the same cycle.
- Capture, for index i = the position of the zero in an_l:
  - Patterns 0-9 use the team-standard encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Pattern 0-9: digit i gets the value and digit_valid[i] is set to 1.
  - Blank 1111111: digit i gets 4'hF and digit_valid[i] is cleared. No error is raised.
  - Any other pattern: digit i gets 4'hE, digit_valid[i] is cleared, and err_invalid is set.
  - In all three cases seen[i] is set to 1.
- Frame:
  - When a capture makes the seen mask all ones, frame_done pulses on the next cycle and seen clears to 0 in that same cycle.
  - Recapturing a digit before the frame completes overwrites its value and leaves seen unchanged.
- Collision: any cycle in which an_r has two or more zero bits sets err_collision and sends the FSM to IDLE.
- clr_err clears both sticky flags. If a set condition occurs in the same cycle as clr_err, the set wins.

## Timing
- Reset values: digits_out = all 4'hF, digit_valid = 0, frame_done = 0, err_invalid = 0, err_collision = 0. Internal state: FSM in IDLE, seen = 0, cnt = 0, an_r = all ones, seg_r = 7'h7F.
- Capture latency:
  - Inputs are applied before edge 1 and held through edge STABLE_CYCLES.
  - digits_out and digit_valid update after edge STABLE_CYCLES+1.
  - The sticky error flags update on that same edge.
- frame_done is asserted for exactly one cycle, on the edge after the capture that completed the frame.
- A glitch shorter than STABLE_CYCLES samples never causes a capture. The count restarts from 1 after any change.
- Reset asserted mid-operation returns everything to its reset value on the next edge. A partial count or partial frame is discarded.
- err_collision sets on the edge after the colliding sample is registered, i.e. 2 edges after the pins.
- Counter width is clog2(STABLE_CYCLES+1). cnt saturates and does not wrap in CAPTURED.

## Test plan
- Reset, then hold an_in=all ones -> all outputs at their reset values, with no captures and no flags.
- With STABLE_CYCLES=4, drive an_in=1110 and seg_in=0100100 for 4 cycles -> digits_out[3:0]=2 and digit_valid[0]=1 after edge 5. Hold for only 3 cycles instead -> no update.
- Scan 4 digits showing 1,2,3,4 (0-based index), 6 cycles each -> digits_out=16'h4321, digit_valid=1111, and frame_done high for 1 cycle after the digit-3 capture. A second scan yields a second pulse.
- Drive seg_in=1111111 on digit 1 -> digit 1 reads 4'hF with valid=0 and no error. Drive 0101010 on digit 2 -> digit 2 reads 4'hE and err_invalid=1. Pulse clr_err -> err_invalid=0.
- Drive an_in=1100 -> err_collision=1 and no capture. Assert clr_err in the same cycle as a new collision -> the flag stays 1.
- Assert rst_n=0 while in COUNT at cnt=3 -> all outputs return to reset values on the next edge, and no capture occurs after release.
